// File: rtl/cpu_run_host_pkg.sv
// Shared encodings for the host run controller.
// CPU state, HALT opcode and host FSM states.
package cpu_run_host_pkg;

  localparam int IR_W = 16;
  localparam int OP_W = 5;

  localparam logic CPU_IDLE = 1'b0;
  localparam logic CPU_EXEC = 1'b1;

  localparam logic [OP_W-1:0] OP_HALT = 5'h1F;

  typedef enum logic [2:0] {
    H_IDLE   = 3'd0,
    H_LAUNCH = 3'd1,
    H_RUN    = 3'd2,
    H_STEP   = 3'd3,
    H_DRAIN  = 3'd4
  } host_state_e;

  // States in which the CPU is held enabled.
  function automatic logic live(host_state_e s);
    return (s == H_LAUNCH) || (s == H_RUN) || (s == H_STEP);
  endfunction

endpackage

// File: rtl/cpu_run_host_if.sv
// CPU control handshake: enable/start out of the host,
// state and writeback IR back from the CPU.
interface cpu_run_host_if;
  import cpu_run_host_pkg::*;

  logic            cpu_enable;
  logic            cpu_start;
  logic            cpu_state;
  logic [IR_W-1:0] wb_ir;

  modport master (
    output cpu_enable,
    output cpu_start,
    input  cpu_state,
    input  wb_ir
  );

  modport slave (
    input  cpu_enable,
    input  cpu_start,
    output cpu_state,
    output wb_ir
  );

endinterface

// File: rtl/cpu_run_watchdog.sv
// Saturating exec-cycle counter with watchdog compare.
// MAX_CYCLES of 0 never expires.
module cpu_run_watchdog #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);
  localparam bit               WD_ON = (MAX_CYCLES != 0);

  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (count_en && (count != '1))
      count <= count + CNT_W'(1);
  end

  // Fires on the cycle whose count brings the total to MAX_CYCLES.
  assign expire = WD_ON && count_en && (count == LIMIT);

endmodule

// File: rtl/cpu_run_host.sv
// Host run controller: run/step/stop to CPU enable/start.
// Optional breakpoint: CPU_RUN_HOST_BREAKPOINT_EN.
module cpu_run_host
  import cpu_run_host_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 1000000,
  parameter int STEP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_stop,
  cpu_run_host_if.master   cpu,
`ifdef CPU_RUN_HOST_BREAKPOINT_EN
  input  logic             bp_valid,
  input  logic [OP_W-1:0]  bp_opcode,
  output logic             bp_hit,
`endif
  output logic             busy,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int SW = $clog2(STEP_CYCLES + 1);

  host_state_e     state_q, state_d;
  logic            step_q, step_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            exec, counting, accept;
  logic            halt_ev, bp_ev, wd_expire;
  logic            set_halt, set_to, set_bp;
  logic [OP_W-1:0] opcode;
  logic            unused_ir;

  assign opcode    = cpu.wb_ir[IR_W-1:IR_W-OP_W];
  assign unused_ir = ^cpu.wb_ir[IR_W-OP_W-1:0];
  assign exec      = (cpu.cpu_state == CPU_EXEC);
  assign counting  = exec &&
                     ((state_q == H_RUN) || (state_q == H_STEP));
  assign accept    = (state_q == H_IDLE) && (cmd_run || cmd_step);
  assign halt_ev   = counting && (opcode == OP_HALT);

`ifdef CPU_RUN_HOST_BREAKPOINT_EN
  assign bp_ev = counting && bp_valid && (opcode == bp_opcode);
`else
  assign bp_ev = 1'b0;
`endif

  cpu_run_watchdog #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_wd (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept),
    .count_en (counting),
    .count    (cycle_count),
    .expire   (wd_expire)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    scnt_d   = scnt_q;
    set_halt = 1'b0;
    set_to   = 1'b0;
    set_bp   = 1'b0;
    unique case (state_q)
      H_IDLE: begin
        if (cmd_run) begin
          state_d = H_LAUNCH;
          step_d  = 1'b0;
        end else if (cmd_step) begin
          state_d = H_LAUNCH;
          step_d  = 1'b1;
        end
      end
      H_LAUNCH: begin
        if (step_q) begin
          state_d = H_STEP;
          scnt_d  = SW'(STEP_CYCLES);
        end else begin
          state_d = H_RUN;
        end
      end
      H_RUN, H_STEP: begin
        // Exit events in strict priority order.
        if (cmd_stop) begin
          state_d = H_DRAIN;
        end else if (halt_ev) begin
          state_d  = H_DRAIN;
          set_halt = 1'b1;
        end else if (bp_ev) begin
          state_d = H_DRAIN;
          set_bp  = 1'b1;
        end else if (wd_expire) begin
          state_d = H_DRAIN;
          set_to  = 1'b1;
        end else if ((state_q == H_STEP) && exec) begin
          if (scnt_q == SW'(1))
            state_d = H_DRAIN;
          else
            scnt_d = scnt_q - SW'(1);
        end
      end
      H_DRAIN: begin
        if (!exec)
          state_d = H_IDLE;
      end
      default: state_d = H_IDLE;
    endcase
  end

  // Outputs follow the next state so they stay registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= H_IDLE;
      step_q         <= 1'b0;
      scnt_q         <= '0;
      cpu.cpu_enable <= 1'b0;
      cpu.cpu_start  <= 1'b0;
      busy           <= 1'b0;
      halted         <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      scnt_q         <= scnt_d;
      cpu.cpu_enable <= live(state_d);
      cpu.cpu_start  <= (state_d == H_LAUNCH);
      busy           <= (state_d != H_IDLE);
      halted         <= !accept && (halted | set_halt);
      timeout        <= !accept && (timeout | set_to);
    end
  end

`ifdef CPU_RUN_HOST_BREAKPOINT_EN
  always_ff @(posedge clock) begin
    if (reset)
      bp_hit <= 1'b0;
    else
      bp_hit <= !accept && (bp_hit | set_bp);
  end
`else
  logic unused_bp;
  assign unused_bp = set_bp;
`endif

endmodule

// File: tb/tb_cpu_run_host.sv
// Directed bench for cpu_run_host with a small CPU model
// and an end-of-run scoreboard.
`timescale 1ns/1ps
module tb_cpu_run_host;
  import cpu_run_host_pkg::*;

  localparam int CW    = 32;
  localparam int MAXC  = 24;
  localparam int STEPC = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_run = 1'b0;
  logic          cmd_step = 1'b0;
  logic          cmd_stop = 1'b0;
  logic          cpu_block = 1'b0;
  logic          busy, halted, timeout;
  logic [CW-1:0] cycle_count;
`ifdef CPU_RUN_HOST_BREAKPOINT_EN
  logic          bp_valid = 1'b0;
  logic [4:0]    bp_opcode = 5'h00;
  logic          bp_hit;
`endif

  cpu_run_host_if bus();

  cpu_run_host #(
    .CNT_W       (CW),
    .MAX_CYCLES  (MAXC),
    .STEP_CYCLES (STEPC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_run     (cmd_run),
    .cmd_step    (cmd_step),
    .cmd_stop    (cmd_stop),
    .cpu         (bus.master),
`ifdef CPU_RUN_HOST_BREAKPOINT_EN
    .bp_valid    (bp_valid),
    .bp_opcode   (bp_opcode),
    .bp_hit      (bp_hit),
`endif
    .busy        (busy),
    .halted      (halted),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  // CPU model: executes whenever enabled, unless held off.
  always @(posedge clock)
    bus.cpu_state <= (bus.cpu_enable === 1'b1) && !cpu_block;

  int start_seen = 0;
  int exec_en    = 0;
  always @(negedge clock) begin
    if (bus.cpu_start === 1'b1) start_seen++;
    if (bus.cpu_state === 1'b1 && bus.cpu_enable === 1'b1)
      exec_en++;
  end

  typedef struct {
    logic          h;
    logic          t;
    logic [CW-1:0] n;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_run(logic h, logic t, int n);
    exp_t e;
    e.h = h;
    e.t = t;
    e.n = CW'(n);
    sb.push_back(e);
  endtask

  task automatic pulse_run();
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
  endtask

  // Leaves the caller inside the n-th exec cycle.
  task automatic to_exec(string tag, int n);
    int  k = 0;
    bit  ok = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.cpu_state === 1'b1) k++;
      if (k == n) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_reach"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(string tag);
    bit   ok = 0;
    logic en_prev = 1'b1;
    exp_t e;
    for (int i = 0; i < 100; i++) begin
      en_prev = bus.cpu_enable;
      tick();
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_idle"}, 64'(ok), 64'd1);
    chk({tag, "_en_low"}, 64'(en_prev), 64'd0);
    chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_halted"}, 64'(halted), 64'(e.h));
      chk({tag, "_timeout"}, 64'(timeout), 64'(e.t));
      chk({tag, "_count"}, 64'(cycle_count), 64'(e.n));
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_en"}, 64'(bus.cpu_enable), 64'd0);
    chk({tag, "_start"}, 64'(bus.cpu_start), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_count"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    int s0, e0;
    bus.wb_ir = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    pulse_stop();
    tick();
    chk("stop_idle_noop", 64'(busy), 64'd0);

    // Run to HALT on exec cycle 20.
    s0 = start_seen;
    expect_run(1'b1, 1'b0, 20);
    pulse_run();
    chk("halt_start", 64'(bus.cpu_start), 64'd1);
    chk("halt_busy", 64'(busy), 64'd1);
    to_exec("halt", 20);
    bus.wb_ir = {OP_HALT, 11'h000};
    tick();
    bus.wb_ir = '0;
    chk("halt_en_drop", 64'(bus.cpu_enable), 64'd0);
    chk("halt_flag", 64'(halted), 64'd1);
    wait_idle("halt");
    chk("halt_start_once", 64'(start_seen - s0), 64'd1);

    // Stop on exec cycle 7.
    expect_run(1'b0, 1'b0, 7);
    pulse_run();
    chk("stop_clr_halted", 64'(halted), 64'd0);
    to_exec("stop", 7);
    pulse_stop();
    chk("stop_en_drop", 64'(bus.cpu_enable), 64'd0);
    wait_idle("stop");

    // Run and step together: run wins.
    expect_run(1'b0, 1'b0, 6);
    cmd_run  = 1'b1;
    cmd_step = 1'b1;
    tick();
    cmd_run  = 1'b0;
    cmd_step = 1'b0;
    to_exec("both", 6);
    pulse_stop();
    wait_idle("both");

    // Step of STEP_CYCLES with a run command ignored.
    e0 = exec_en;
    expect_run(1'b0, 1'b0, STEPC);
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    tick();
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    wait_idle("step");
    chk("step_exec_en", 64'(exec_en - e0), 64'(STEPC));
    repeat (2) tick();
    chk("step_run_ignored", 64'(busy), 64'd0);

    // Watchdog expiry, then a new run clears it.
    expect_run(1'b0, 1'b1, MAXC);
    pulse_run();
    wait_idle("wd");
    chk("wd_en", 64'(bus.cpu_enable), 64'd0);
    expect_run(1'b0, 1'b0, 2);
    pulse_run();
    chk("wd_clr_timeout", 64'(timeout), 64'd0);
    chk("wd_clr_count", 64'(cycle_count), 64'd0);
    to_exec("wd2", 2);
    pulse_stop();
    wait_idle("wd2");

    // Reset on exec cycle 5.
    pulse_run();
    to_exec("rst", 5);
    reset = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    tick();
    expect_run(1'b0, 1'b0, 3);
    pulse_run();
    to_exec("rst2", 3);
    pulse_stop();
    wait_idle("rst2");

    // CPU held off after launch: wait without counting.
    cpu_block = 1'b1;
    expect_run(1'b0, 1'b0, 2);
    pulse_run();
    repeat (4) tick();
    chk("blk_busy", 64'(busy), 64'd1);
    chk("blk_en", 64'(bus.cpu_enable), 64'd1);
    chk("blk_count", 64'(cycle_count), 64'd0);
    cpu_block = 1'b0;
    to_exec("blk", 2);
    pulse_stop();
    wait_idle("blk");

`ifdef CPU_RUN_HOST_BREAKPOINT_EN
    bp_valid  = 1'b1;
    bp_opcode = 5'h03;
    expect_run(1'b0, 1'b0, 4);
    pulse_run();
    to_exec("bp", 4);
    bus.wb_ir = {5'h03, 11'h000};
    tick();
    bus.wb_ir = '0;
    chk("bp_hit", 64'(bp_hit), 64'd1);
    chk("bp_en_drop", 64'(bus.cpu_enable), 64'd0);
    wait_idle("bp");
    chk("bp_hit_sticky", 64'(bp_hit), 64'd1);
    bp_valid = 1'b0;
    expect_run(1'b0, 1'b0, 1);
    pulse_run();
    chk("bp_clr", 64'(bp_hit), 64'd0);
    to_exec("bp2", 1);
    pulse_stop();
    wait_idle("bp2");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

endmodule
